uart_tx_frame: RTL

Parametrised UART transmitter with a one-entry holding buffer, a valid/ready byte input, CTS-gated frame start and RTS request output. It replaces the fixed-format transmitter in the serial datapath. Data width, bit order and the four baud divisors are compile-time; parity, parity sense, stop-bit count and baud selection are run-time via `MODE`. A frame is sent continuously once started, and a queued byte follows back-to-back.

---
 rtl/uart_tx_frame_if.sv | 11 +
 rtl/uart_tx_frame.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a producer and the UART transmitter's holding buffer.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] DATA_IN;
   logic                 DATA_VALID;
   logic                 DATA_READY;

   modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
   modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-entry holding buffer, CTS-gated frame start, run-time
// parity/stop/baud via MODE, back-to-back frames with no idle gap.
module uart_tx_frame #(
   parameter int DATA_BITS = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int DIV0      = 10416,
   parameter int DIV1      = 5208,
   parameter int DIV2      = 2604,
   parameter int DIV3      = 868
) (
   input  logic             Clock,
   input  logic             Reset,
   uart_tx_frame_if.slave   data_if,
   input  logic [4:0]       MODE,
   input  logic             CTS,
   output logic             DATA_OUT,
   output logic             RTS,
   output logic             BUSY,
   output logic             FRAME_DONE
);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

   state_t               state_q, state_d;
   logic [15:0]          cnt_q, div_q, div_sel;
   logic                 par_en_q, two_stop_q, par_q;
   logic [DATA_BITS-1:0] shreg_q, shreg_d, hold_q;
   logic [IW-1:0]        bit_q, bit_d;
   logic                 hold_full_q, hold_full_d, ready_q;
   logic                 line_q, line_d, rts_q, rts_d, fd_q;
   logic                 tick, eof, start, accept, last_bit;

   assign tick     = (state_q != S_IDLE) && (cnt_q == div_q - 16'd1);
   assign eof      = tick && ((state_q == S_STOP1 && !two_stop_q) || state_q == S_STOP2);
   assign start    = (state_q == S_IDLE || eof) && hold_full_q && CTS;
   assign accept   = data_if.DATA_VALID && ready_q;
   assign last_bit = (bit_q == IW'(DATA_BITS - 1));

   always_comb begin
      div_sel = 16'(DIV0);
      case (MODE[1:0])
         2'b01:   div_sel = 16'(DIV1);
         2'b10:   div_sel = 16'(DIV2);
         2'b11:   div_sel = 16'(DIV3);
         default: div_sel = 16'(DIV0);
      endcase
   end

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_START;
         S_START:  if (tick) state_d = S_DATA;
         S_DATA:   if (tick && last_bit) state_d = par_en_q ? S_PARITY : S_STOP1;
         S_PARITY: if (tick) state_d = S_STOP1;
         S_STOP1:  if (tick) state_d = two_stop_q ? S_STOP2 : (start ? S_START : S_IDLE);
         S_STOP2:  if (tick) state_d = start ? S_START : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output logic: line level and RTS are decoded from the next state so
   // that both are registered and change on the same edge as the state.
   always_comb begin
      shreg_d     = shreg_q;
      bit_d       = bit_q;
      hold_full_d = hold_full_q;
      if (accept)     hold_full_d = 1'b1;
      else if (start) hold_full_d = 1'b0;
      if (start) begin
         shreg_d = hold_q;
         bit_d   = '0;
      end else if (state_q == S_DATA && tick) begin
         shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         bit_d   = bit_q + IW'(1);
      end
      case (state_d)
         S_START:  line_d = 1'b0;
         S_DATA:   line_d = MSB_FIRST ? shreg_d[DATA_BITS-1] : shreg_d[0];
         S_PARITY: line_d = par_q;
         default:  line_d = 1'b1;
      endcase
      rts_d = hold_full_d || (state_d != S_IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q       <= '0;
         div_q       <= 16'd2;
         par_en_q    <= 1'b0;
         two_stop_q  <= 1'b0;
         par_q       <= 1'b0;
         shreg_q     <= '0;
         bit_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b1;
         line_q      <= 1'b1;
         rts_q       <= 1'b0;
         fd_q        <= 1'b0;
      end else begin
         if (start || tick || state_q == S_IDLE) cnt_q <= '0;
         else                                    cnt_q <= cnt_q + 16'd1;
         // Frame format is frozen at start; parity comes from the shifter copy.
         if (start) begin
            div_q      <= div_sel;
            par_en_q   <= MODE[2];
            two_stop_q <= MODE[4];
            par_q      <= (^shreg_d) ^ MODE[3];
         end
         if (accept) hold_q <= data_if.DATA_IN;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         hold_full_q <= hold_full_d;
         ready_q     <= !hold_full_d;
         line_q      <= line_d;
         rts_q       <= rts_d;
         fd_q        <= eof;
      end
   end

   assign data_if.DATA_READY = ready_q;
   assign DATA_OUT           = line_q;
   assign RTS                = rts_q;
   assign BUSY               = (state_q != S_IDLE);
   assign FRAME_DONE         = fd_q;
endmodule
